mux_arb_n: RTL and testbench
============================

// Module: mux_arb_n
// PURPOSE
//  N-way, WIDTH-bit handshaked multiplexer with a registered output stage.
//  Selects one of N valid/ready source channels and forwards its word downstream.
//  Selection uses either an external select (MODE=0) or a round-robin arbiter (MODE=1).
//  Used where several producers share one 32-bit datapath port (e.g. fetch/load/store to one memory port).
// PARAMETERS
//  WIDTH  32  data width per channel
//  N      4   number of input channels, >= 2
//  SELW   $clog2(N)  select/index width (derived; do not override)
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  mode       in   1        0 = external select, 1 = round-robin
//  sel        in   SELW     channel index used when mode=0
//  in_valid   in   N        per-channel valid; bit i = channel i
//  in_ready   out  N        per-channel ready (combinational)
//  in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  out_valid  out  1        output register holds a word
//  out_ready  in   1        downstream accepts the word
//  out_data   out  WIDTH    registered data
//  out_sel    out  SELW     index of the channel that supplied out_data
// BEHAVIOUR
//  Reset (async on rst_n=0): out_valid=0, out_data=0, out_sel=0, rr_ptr=0; held while rst_n=0.
//  Reset mid-transfer: the held word is dropped; no in_ready asserted while rst_n=0.
//  load_en = !out_valid || out_ready  (single-entry pipe; full throughput, no bubble).
//  Grant (combinational, at most one bit set):
//   mode=0: grant[sel] = in_valid[sel]. sel >= N -> no grant. Other channels are never granted.
//   mode=1: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N (wrap-around).
//  in_ready[i] = load_en && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
//  On a transfer: out_data <= in_data[i], out_sel <= i, out_valid <= 1 (latency 1 cycle).
//  No transfer and out_ready && out_valid: out_valid <= 0; out_data/out_sel hold their values.
//  No transfer and !out_ready: output stage holds all values.
//  Simultaneous drain and load: the new word replaces the old one in the same edge; out_valid stays 1.
//  rr_ptr: on a transfer while mode=1, rr_ptr <= (i == N-1) ? 0 : i+1. rr_ptr is unchanged otherwise,
//   including transfers in mode=0.
//  mode/sel changes take effect combinationally in the same cycle. The held output word is unaffected.
//  in_valid has no retract requirement here; the arbiter re-evaluates every cycle.
//  Sources are responsible for holding in_valid/in_data until accepted.
//  Fairness: with all N channels valid and out_ready=1, mode=1 grants 0,1,..,N-1,0,... one per cycle.
//  Width rules: out_sel is zero-extended where N is not a power of two; indices >= N are never produced.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately.
//  2 mode=0, sel=2, in_valid=4'b1111, in_data ch2=32'hDEAD_BEEF, out_ready=1:
//    only in_ready[2]=1; next cycle out_valid=1, out_data=DEAD_BEEF, out_sel=2.
//  3 mode=1, all valid, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1.
//    Each sample shows the matching data word.
//  4 mode=1, rr_ptr=3, only ch1 valid -> ch1 granted (wrap-around search), rr_ptr becomes 2.
//  5 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data stable.
//    Then out_ready=1 with ch0 valid -> new word loads in the same edge, out_valid stays 1.
//  6 mode=0 with sel=5 at N=6 vs sel=7 at N=6 (SELW=3):
//    sel=5 grants ch5; sel=7 yields no grant and out_valid falls after the drain.

Source files
------------

// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N valid/ready source channels in, one registered channel out.
// SELW is derived from N and should be left at its default.
interface mux_arb_n_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
);
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [N-1:0]         in_valid;
   logic [N-1:0]         in_ready;
   logic [N*WIDTH-1:0]   in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_sel;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux_arb_n.sv
// N-way handshaked multiplexer with a single registered output stage.
// Channel choice comes from an external select (mode=0) or a round-robin arbiter (mode=1).
module mux_arb_n #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_arb_n_if.slave   bus
);

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SELW-1:0]   out_sel_q,   out_sel_d;
   logic [SELW-1:0]   rr_ptr_q,    rr_ptr_d;

   logic [N-1:0]      grant;
   logic [SELW-1:0]   grant_idx;
   logic              grant_any;
   logic              load_en;
   logic              xfer;
   int                idx;

   assign load_en = !out_valid_q || bus.out_ready;

   // Grant is one-hot or empty; round-robin searches upward from rr_ptr with wrap-around.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (!bus.mode) begin
         if (int'(bus.sel) < N) begin
            grant[bus.sel] = bus.in_valid[bus.sel];
            grant_idx      = bus.sel;
            grant_any      = bus.in_valid[bus.sel];
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!grant_any && bus.in_valid[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = SELW'(idx);
               grant_any  = 1'b1;
            end
         end
      end
   end

   assign xfer         = load_en && grant_any;
   assign bus.in_ready = (rst_n && load_en) ? grant : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
         out_sel_d   = grant_idx;
         // Only arbitrated transfers advance the pointer; externally selected ones leave it alone.
         if (bus.mode) begin
            rr_ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: stimulus pushes expected words, per-DUT monitors pop on each drain.
// A 4-channel and a 6-channel instance share clock and reset.
module tb_mux_arb_n;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  sel;
   } exp_t;

   logic clk;
   logic rst_n;

   int checks_passed;
   int checks_total;

   exp_t q4[$];
   exp_t q6[$];
   exp_t e4;
   exp_t e6;

   logic [31:0] data4 [4];
   logic [31:0] data6 [6];

   mux_arb_n_if #(.WIDTH(32), .N(4)) bus4 ();
   mux_arb_n_if #(.WIDTH(32), .N(6)) bus6 ();

   mux_arb_n #(.WIDTH(32), .N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   mux_arb_n #(.WIDTH(32), .N(6)) dut6 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus6)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic mode, input logic [1:0] sel, input logic [3:0] valid, input logic oready);
      bus4.mode      = mode;
      bus4.sel       = sel;
      bus4.in_valid  = valid;
      bus4.out_ready = oready;
   endtask

   task automatic applyStimulus6(input logic mode, input logic [2:0] sel, input logic [5:0] valid, input logic oready);
      bus6.mode      = mode;
      bus6.sel       = sel;
      bus6.in_valid  = valid;
      bus6.out_ready = oready;
   endtask

   task automatic expectGrant(input string name, input logic [3:0] exp_ready);
      #1;
      checkOutput(name, 64'(bus4.in_ready), 64'(exp_ready));
      for (int i = 0; i < 4; i++) begin
         if (exp_ready[i]) q4.push_back({data4[i], 3'(i)});
      end
   endtask

   task automatic expectGrant6(input string name, input logic [5:0] exp_ready);
      #1;
      checkOutput(name, 64'(bus6.in_ready), 64'(exp_ready));
      for (int i = 0; i < 6; i++) begin
         if (exp_ready[i]) q6.push_back({data6[i], 3'(i)});
      end
   endtask

   // Each drained word is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && bus4.out_valid && bus4.out_ready) begin
         if (q4.size() == 0) begin
            checkOutput("n4_unexpected_word", 64'(bus4.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e4 = q4.pop_front();
            checkOutput("n4_data", 64'(bus4.out_data), 64'(e4.data));
            checkOutput("n4_sel", 64'(bus4.out_sel), 64'(e4.sel));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus6.out_valid && bus6.out_ready) begin
         if (q6.size() == 0) begin
            checkOutput("n6_unexpected_word", 64'(bus6.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e6 = q6.pop_front();
            checkOutput("n6_data", 64'(bus6.out_data), 64'(e6.data));
            checkOutput("n6_sel", 64'(bus6.out_sel), 64'(e6.sel));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int seq [6] = '{0, 1, 2, 3, 0, 1};
      checks_passed = 0;
      checks_total  = 0;
      clk   = 1'b0;
      rst_n = 1'b0;

      data4[0] = 32'h1111_0000;
      data4[1] = 32'h2222_0001;
      data4[2] = 32'hDEAD_BEEF;
      data4[3] = 32'h4444_0003;
      for (int i = 0; i < 6; i++) data6[i] = 32'h6000_0000 + 32'(i);
      bus4.in_data = {data4[3], data4[2], data4[1], data4[0]};
      bus6.in_data = {data6[5], data6[4], data6[3], data6[2], data6[1], data6[0]};

      // Inputs look ready-to-go during reset, but nothing may be granted.
      applyStimulus(1'b0, 2'd2, 4'hF, 1'b1);
      applyStimulus6(1'b0, 3'd0, 6'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(bus4.out_data), 64'd0);
      checkOutput("rst_out_sel", 64'(bus4.out_sel), 64'd0);
      checkOutput("rst_in_ready", 64'(bus4.in_ready), 64'd0);

      // External select picks channel 2 only.
      rst_n = 1'b1;
      expectGrant("t2_ready", 4'b0100);
      tick();
      applyStimulus(1'b0, 2'd2, 4'h0, 1'b1);
      checkOutput("t2_out_valid", 64'(bus4.out_valid), 64'd1);
      tick();

      // Round-robin fairness with every channel valid.
      applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
      for (int k = 0; k < 6; k++) begin
         expectGrant("t3_rr_ready", 4'(4'b0001 << seq[k]));
         tick();
      end
      expectGrant("t4_pre_ready", 4'b0100);
      tick();

      // Pointer at 3 with only channel 1 valid: search wraps to 1, pointer becomes 2.
      applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1);
      expectGrant("t4_wrap_ready", 4'b0010);
      tick();
      applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
      expectGrant("t4_ptr_ready", 4'b0100);
      tick();
      applyStimulus(1'b1, 2'd0, 4'h0, 1'b1);
      tick();

      // Backpressure holds the word; then drain and reload on the same edge.
      applyStimulus(1'b0, 2'd3, 4'b1000, 1'b0);
      expectGrant("t5_load_ready", 4'b1000);
      tick();
      for (int k = 0; k < 3; k++) begin
         expectGrant("t5_bp_ready", 4'b0000);
         checkOutput("t5_bp_valid", 64'(bus4.out_valid), 64'd1);
         checkOutput("t5_bp_data", 64'(bus4.out_data), 64'(data4[3]));
         tick();
      end
      applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1);
      expectGrant("t5_swap_ready", 4'b0001);
      tick();
      checkOutput("t5_swap_valid", 64'(bus4.out_valid), 64'd1);
      checkOutput("t5_swap_data", 64'(bus4.out_data), 64'(data4[0]));
      applyStimulus(1'b0, 2'd0, 4'h0, 1'b1);
      tick();
      checkOutput("t5_drained_valid", 64'(bus4.out_valid), 64'd0);

      // Six-channel instance: in-range and out-of-range selects.
      applyStimulus6(1'b0, 3'd5, 6'h3F, 1'b1);
      expectGrant6("t6_sel5_ready", 6'b100000);
      tick();
      applyStimulus6(1'b0, 3'd7, 6'h3F, 1'b1);
      expectGrant6("t6_sel7_ready", 6'b000000);
      tick();
      checkOutput("t6_sel7_valid", 64'(bus6.out_valid), 64'd0);
      applyStimulus6(1'b0, 3'd6, 6'h3F, 1'b1);
      expectGrant6("t6_sel6_ready", 6'b000000);
      tick();
      applyStimulus6(1'b1, 3'd0, 6'b000100, 1'b1);
      expectGrant6("t6_rr_ch2", 6'b000100);
      tick();
      applyStimulus6(1'b1, 3'd0, 6'b100001, 1'b1);
      expectGrant6("t6_rr_ch5", 6'b100000);
      tick();
      applyStimulus6(1'b1, 3'd0, 6'b100010, 1'b1);
      expectGrant6("t6_rr_wrap_ch1", 6'b000010);
      tick();
      applyStimulus6(1'b0, 3'd0, 6'h00, 1'b1);
      tick();

      // Reset in the middle of a held word drops it and clears the pointer.
      applyStimulus(1'b0, 2'd3, 4'b1000, 1'b0);
      expectGrant("t1_load_ready", 4'b1000);
      tick();
      checkOutput("t1_held_valid", 64'(bus4.out_valid), 64'd1);
      rst_n = 1'b0;
      q4.delete();
      #1;
      checkOutput("t1_rst_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("t1_rst_data", 64'(bus4.out_data), 64'd0);
      checkOutput("t1_rst_sel", 64'(bus4.out_sel), 64'd0);
      checkOutput("t1_rst_ready", 64'(bus4.in_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
      expectGrant("t1_rr_after_reset", 4'b0001);
      tick();
      applyStimulus(1'b1, 2'd0, 4'h0, 1'b1);
      applyStimulus6(1'b0, 3'd0, 6'h00, 1'b1);
      tick();
      tick();

      checkOutput("q4_left_over", 64'(q4.size()), 64'd0);
      checkOutput("q6_left_over", 64'(q6.size()), 64'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
